// File: rtl/fp_div_pkg.sv
// Shared types, constants and operand unpacking for the sequential binary32 divider.
package fp_div_pkg;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned DIV_STEPS  = 25;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Result class decided during unpack; SPEC_NONE means the divided significand is used.
  typedef enum logic [2:0] {
    SPEC_NONE = 3'd0,
    SPEC_NAN  = 3'd1,
    SPEC_DBZ  = 3'd2,
    SPEC_INF  = 3'd3,
    SPEC_ZERO = 3'd4
  } spec_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp_unpacked_t;

  // Subnormals are flushed to zero; inf/NaN keep their raw significand (never used).
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign    = x[31];
    u.exp     = 10'(x[30:23]);
    u.is_zero = (x[30:23] == 8'd0);
    u.is_inf  = (x[30:23] == FP_EXP_MAX) && (x[22:0] == 23'd0);
    u.is_nan  = (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
    u.sig     = u.is_zero ? 24'd0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Iterative restoring radix-2 significand divider: one quotient bit per clock after load.
module fp_div_core
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [24:0] sig_a,
  input  logic [23:0] sig_b,
  output logic [24:0] q,
  output logic        sticky,
  output logic        step_done
);

  localparam int unsigned REM_W = 25;
  localparam int unsigned CNT_W = 5;

  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] q_q, q_d;
  logic [23:0]      div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_done_q, step_done_d;
  logic             ge;
  logic [REM_W-1:0] diff;

  // Counter parks at DIV_STEPS when idle so no stepping occurs until the next load.
  always_comb begin
    rem_d = rem_q;
    q_d   = q_q;
    div_d = div_q;
    cnt_d = cnt_q;
    ge    = 1'b0;
    diff  = rem_q;
    if (load) begin
      rem_d = sig_a;
      q_d   = '0;
      div_d = sig_b;
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(DIV_STEPS)) begin
      ge    = (rem_q >= {1'b0, div_q});
      diff  = ge ? (rem_q - {1'b0, div_q}) : rem_q;
      rem_d = diff << 1;
      q_d   = {q_q[REM_W-2:0], ge};
      cnt_d = cnt_q + CNT_W'(1);
    end
    step_done_d = (cnt_d == CNT_W'(DIV_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt_q       <= CNT_W'(DIV_STEPS);
      step_done_q <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      q_q         <= q_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      step_done_q <= step_done_d;
    end
  end

  assign q         = q_q;
  assign sticky    = |rem_q;
  assign step_done = step_done_q;

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle binary32 divider with start/done handshake and fixed 28-cycle latency.
// Optional FP_DIV_INEXACT_EN adds a registered inexact output.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter bit          ROUND_NEAREST = 1'b1,
  parameter int unsigned EXP_BIAS      = FP_BIAS
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
`ifdef FP_DIV_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  localparam int unsigned EXP_W = 10;

  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  spec_t spec_q, spec_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;
`ifdef FP_DIV_INEXACT_EN
  logic inx_q, inx_d;
`endif

  fp_unpacked_t ua, ub;
  logic pre_shift;
  spec_t spec_u;
  logic core_load;
  logic [24:0] core_sig_a;
  logic [23:0] core_sig_b;
  logic [24:0] core_q;
  logic core_sticky, core_step_done;

  logic inc;
  logic [24:0] sum;
  logic carry;
  logic signed [EXP_W-1:0] exp_r;
  logic ovf_r, unf_r;

  fp_div_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load),
    .sig_a     (core_sig_a),
    .sig_b     (core_sig_b),
    .q         (core_q),
    .sticky    (core_sticky),
    .step_done (core_step_done)
  );

  // Unpack and classify the captured operands; pre-normalise so the quotient lies in [1,2).
  always_comb begin
    ua         = fp_unpack(a_q);
    ub         = fp_unpack(b_q);
    pre_shift  = (ua.sig < ub.sig);
    core_sig_a = pre_shift ? {ua.sig, 1'b0} : {1'b0, ua.sig};
    core_sig_b = ub.sig;
    core_load  = (state_q == UNPACK);
    if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf))
      spec_u = SPEC_NAN;
    else if (!ua.is_inf && ub.is_zero)
      spec_u = SPEC_DBZ;
    else if (ua.is_inf)
      spec_u = SPEC_INF;
    else if (ua.is_zero || ub.is_inf)
      spec_u = SPEC_ZERO;
    else
      spec_u = SPEC_NONE;
  end

  // Rounding: a carry into 2.0 shows up as sum[24:23]==2'b10 with an all-zero fraction.
  always_comb begin
    inc   = ROUND_NEAREST ? (core_q[0] & (core_sticky | core_q[1])) : 1'b0;
    sum   = {1'b0, core_q[24:1]} + 25'(inc);
    carry = (sum[24:23] == 2'b10);
    exp_r = exp_q + $signed(EXP_W'(carry));
    ovf_r = (exp_r >= 10'sd255);
    unf_r = (exp_r <= 10'sd0);
  end

  // Next state and registered outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    spec_d  = spec_q;
    quot_d  = quot_q;
    exc_d   = exc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
`ifdef FP_DIV_INEXACT_EN
    inx_d   = inx_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end else begin
          state_d = IDLE;
        end
      end
      UNPACK: begin
        sign_d  = ua.sign ^ ub.sign;
        exp_d   = $signed(ua.exp - ub.exp + EXP_W'(EXP_BIAS) - EXP_W'(pre_shift));
        spec_d  = spec_u;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        if (core_step_done) state_d = ROUND;
      end
      ROUND: begin
        exc_d   = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        dbz_d   = 1'b0;
`ifdef FP_DIV_INEXACT_EN
        inx_d   = 1'b0;
`endif
        unique case (spec_q)
          SPEC_NAN: begin
            quot_d = FP_QNAN;
            exc_d  = 1'b1;
          end
          SPEC_DBZ: begin
            quot_d = {sign_q, FP_EXP_MAX, 23'd0};
            dbz_d  = 1'b1;
            exc_d  = 1'b1;
          end
          SPEC_INF:  quot_d = {sign_q, FP_EXP_MAX, 23'd0};
          SPEC_ZERO: quot_d = {sign_q, 31'd0};
          default: begin
            if (ovf_r) begin
              quot_d = {sign_q, FP_EXP_MAX, 23'd0};
              ovf_d  = 1'b1;
              exc_d  = 1'b1;
            end else if (unf_r) begin
              quot_d = {sign_q, 31'd0};
              unf_d  = 1'b1;
              exc_d  = 1'b1;
            end else begin
              quot_d = {sign_q, exp_r[7:0], sum[22:0]};
            end
`ifdef FP_DIV_INEXACT_EN
            inx_d = core_q[0] | core_sticky | ovf_r | unf_r;
`endif
          end
        endcase
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == UNPACK) || (state_d == DIVIDE) || (state_d == ROUND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      spec_q  <= SPEC_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      exc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef FP_DIV_INEXACT_EN
      inx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      spec_q  <= spec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      exc_q   <= exc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
`ifdef FP_DIV_INEXACT_EN
      inx_q   <= inx_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign exception   = exc_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;
`ifdef FP_DIV_INEXACT_EN
  assign inexact     = inx_q;
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: round-to-nearest and truncating instances share stimulus.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy, done, exception, overflow, underflow, div_by_zero;
  logic [31:0] quotient;
  logic        t_busy, t_done, t_exception, t_overflow, t_underflow, t_div_by_zero;
  logic [31:0] t_quotient;
  logic [31:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq #(.ROUND_NEAREST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .exception(exception),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  fp_div_seq #(.ROUND_NEAREST(1'b0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(t_busy), .done(t_done), .quotient(t_quotient), .exception(t_exception),
    .overflow(t_overflow), .underflow(t_underflow), .div_by_zero(t_div_by_zero)
  );

  // {exception, overflow, underflow, div_by_zero}
  assign flags = {28'd0, exception, overflow, underflow, div_by_zero};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    a     = aa;
    b     = bb;
    start = 1'b1;
  endtask

  // Counts posedges from the accept edge (counted as 1) until done; gives up after 40.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) return;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp_q, input logic [3:0] exp_f,
                        input logic [31:0] exp_tq);
    int lat;
    issue(aa, bb);
    wait_done(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd28);
    check_eq({tag, "_quotient"}, quotient, exp_q);
    check_eq({tag, "_flags"}, flags, 32'(exp_f));
    check_eq({tag, "_trunc_quotient"}, t_quotient, exp_tq);
  endtask

  initial begin
    int lat;
    int n_done;

    #2;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_quotient", quotient, 32'd0);
    check_eq("reset_flags", flags, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 32'h40400000);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 32'h3EAAAAAA);
    run_op("two_by_three", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 32'h3F2AAAAA);
    run_op("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 32'hC0400000);
    run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1001, 32'h7F800000);
    run_op("neg_one_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1001, 32'hFF800000);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 32'h7FC00000);
    run_op("nan_operand", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 32'h7FC00000);
    run_op("inf_by_two",  32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 32'h7F800000);
    run_op("zero_by_five", 32'h00000000, 32'h40A00000, 32'h00000000, 4'b0000, 32'h00000000);
    run_op("one_by_inf",  32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 32'h00000000);
    run_op("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1100, 32'h7F800000);
    run_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 4'b1010, 32'h00000000);

    // start held high while busy, operands changed mid-flight: must not disturb the result
    issue(32'h40C00000, 32'h40000000);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        a = 32'h3F800000;
        b = 32'h00000000;
      end
      if (lat == 10) start = 1'b0;
      if (done) break;
    end
    check_eq("held_start_latency", 32'(lat), 32'd28);
    check_eq("held_start_quotient", quotient, 32'h40400000);
    check_eq("held_start_flags", flags, 32'd0);
    n_done = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("held_start_no_second_done", 32'(n_done), 32'd0);
    check_eq("held_start_idle_busy", 32'(busy), 32'd0);

    // back-to-back: second start issued during the DONE cycle
    issue(32'h3F800000, 32'h40400000);
    wait_done(lat);
    check_eq("b2b_first_latency", 32'(lat), 32'd28);
    check_eq("b2b_first_quotient", quotient, 32'h3EAAAAAB);
    a     = 32'h7F000000;
    b     = 32'h3E800000;
    start = 1'b1;
    wait_done(lat);
    check_eq("b2b_second_latency", 32'(lat), 32'd28);
    check_eq("b2b_second_quotient", quotient, 32'h7F800000);
    check_eq("b2b_second_flags", flags, 32'h0000000C);

    // reset in the middle of an operation
    issue(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_busy", 32'(busy), 32'd0);
    check_eq("midreset_done", 32'(done), 32'd0);
    check_eq("midreset_quotient", quotient, 32'd0);
    check_eq("midreset_flags", flags, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("midreset_no_done", 32'(n_done), 32'd0);

    run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 32'h40400000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
